// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit_pkg
// Purpose  : Shared types and constants for the instruction fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
package instr_fetch_unit_pkg;

  localparam int unsigned c_instr_w  = 32;
  localparam int unsigned c_opcode_w = 7;

  // REQ: may issue, WAIT: response pending, DROP: pending response is stale
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [c_instr_w-1:0] pc;
    logic [c_instr_w-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : DEPTH-entry instruction buffer with push, pop and flush.
//            Head entry reads as zero when the buffer is empty.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  fetch_entry_t i_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic         o_empty,
  output logic         o_full,
  output fetch_entry_t o_head
);

  localparam int unsigned          c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned          c_cnt_w = $clog2(DEPTH + 1);
  localparam logic [c_ptr_w-1:0]   c_last  = c_ptr_w'(DEPTH - 1);
  localparam logic [c_cnt_w-1:0]   c_depth = c_cnt_w'(DEPTH);

  fetch_entry_t       r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign w_do_push = i_push && (r_count != c_depth);
  assign w_do_pop  = i_pop && (r_count != '0);

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == c_depth);
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  // Entry storage: written at the tail on push, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy tracking; flush empties the buffer outright
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Sequential instruction fetcher with one outstanding memory
//            request, redirect support and a small decoupling buffer.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req_valid,
  output logic [c_instr_w-1:0]  imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_rsp_valid,
  input  logic [c_instr_w-1:0]  imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [c_instr_w-1:0]  redirect_pc,
  output logic                  inst_valid,
  output logic [c_instr_w-1:0]  inst_data,
  output logic [c_instr_w-1:0]  inst_pc,
  output logic [c_opcode_w-1:0] inst_opcode,
  input  logic                  inst_ready
);

  fetch_state_t         r_state;
  logic [c_instr_w-1:0] r_pc;
  logic [c_instr_w-1:0] r_fetch_pc;
  logic                 r_run;

  logic         w_hs;
  logic         w_push;
  logic         w_pop;
  logic         w_empty;
  logic         w_full;
  fetch_entry_t w_push_entry;
  fetch_entry_t w_head;
  logic         w_unused_ok;

  // r_run holds off the first request until one edge after reset release
  assign imem_req_valid = r_run && (r_state == REQ) && !w_full;
  assign imem_req_addr  = r_pc;
  assign w_hs           = imem_req_valid && imem_req_ready;

  // A response in the redirect cycle belongs to the old stream
  assign w_push       = (r_state == WAIT) && imem_rsp_valid && !redirect_valid;
  assign w_pop        = inst_valid && inst_ready;
  assign w_push_entry = '{pc: r_fetch_pc, instr: imem_rsp_data};

  assign inst_valid  = !w_empty;
  assign inst_data   = w_head.instr;
  assign inst_pc     = w_head.pc;
  assign inst_opcode = w_head.instr[c_opcode_w-1:0];

  // Redirect targets are word aligned; low bits are intentionally dropped
  assign w_unused_ok = &{1'b0, redirect_pc[1:0]};

  // Fetch FSM: issue, await response, or discard a stale response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= REQ;
      r_pc       <= RESET_PC;
      r_fetch_pc <= '0;
      r_run      <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (redirect_valid) begin
        r_pc    <= {redirect_pc[c_instr_w-1:2], 2'b00};
        r_state <= (w_hs || ((r_state != REQ) && !imem_rsp_valid)) ? DROP : REQ;
      end else begin
        case (r_state)
          REQ: begin
            if (w_hs) begin
              r_fetch_pc <= r_pc;
              r_pc       <= r_pc + 32'd4;
              r_state    <= WAIT;
            end
          end
          WAIT: begin
            if (imem_rsp_valid) r_state <= REQ;
          end
          DROP: begin
            if (imem_rsp_valid) r_state <= REQ;
          end
          default: r_state <= REQ;
        endcase
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_head  (w_head)
  );

endmodule
`default_nettype wire
